// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready handshake, optional skid entry,
// synchronous flush. Control payload is zeroed whenever the stage empties.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_EMPTY  | no valid entry, out_valid=0, out_ctrl=0
// ST_FULL1  | main entry M valid and driving out_*
// ST_FULL2  | M and skid entry S valid, in_ready=0 (SKID=1 only)
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic              accept, drain;
  logic              ld_m_in, ld_m_s, ld_s, clr_ctrl;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;

  // With a skid entry in_ready is a pure state decode, so out_ready never reaches it.
  assign in_ready  = SKID ? (state_q != ST_FULL2) : (!out_valid || out_ready);

  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_m_in  = 1'b0;
    ld_m_s   = 1'b0;
    ld_s     = 1'b0;
    clr_ctrl = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      clr_ctrl = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL1;
            ld_m_in = 1'b1;
          end
        end
        ST_FULL1: begin
          if (accept && drain) begin
            ld_m_in = 1'b1;
          end else if (accept && SKID) begin
            state_d = ST_FULL2;
            ld_s    = 1'b1;
          end else if (drain) begin
            state_d  = ST_EMPTY;
            clr_ctrl = 1'b1;
          end
        end
        ST_FULL2: begin
          if (drain) begin
            state_d = ST_FULL1;
            ld_m_s  = 1'b1;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          clr_ctrl = 1'b1;
        end
      endcase
    end
  end

  // Data is left stale on empty; only ctrl is cleared so a bubble cannot write state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data <= '0;
      m_ctrl <= '0;
      s_data <= '0;
      s_ctrl <= '0;
    end else begin
      if (ld_m_in) begin
        m_data <= in_data;
        m_ctrl <= in_ctrl;
      end else if (ld_m_s) begin
        m_data <= s_data;
        m_ctrl <= s_ctrl;
      end else if (clr_ctrl) begin
        m_ctrl <= '0;
      end
      if (ld_s) begin
        s_data <= in_data;
        s_ctrl <= in_ctrl;
      end
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_FULL1: occupancy = 2'd1;
      ST_FULL2: occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus, each
// tracked by its own queue scoreboard.
module tb_pipe_stage_reg;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              iv;
  logic [31:0]       id;
  logic [3:0]        ic;
  logic              ordy;
  logic [1:0]        ir;
  logic [1:0]        ov;
  logic [1:0][31:0]  od;
  logic [1:0][3:0]   oc;
  logic [1:0][1:0]   occ;

  int checks = 0;
  int errors = 0;

  logic [35:0] sb1[$];
  logic [35:0] sb0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(iv), .in_ready(ir[1]), .in_data(id), .in_ctrl(ic),
    .out_valid(ov[1]), .out_ready(ordy), .out_data(od[1]), .out_ctrl(oc[1]),
    .occupancy(occ[1])
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(iv), .in_ready(ir[0]), .in_data(id), .in_ctrl(ic),
    .out_valid(ov[0]), .out_ready(ordy), .out_data(od[0]), .out_ctrl(oc[0]),
    .occupancy(occ[0])
  );

  // One clock: compare both DUTs against their scoreboards, then advance the models.
  task automatic step();
    int          n;
    logic [35:0] f;
    logic        exp_ir;
    logic [1:0]  acc, drn;
    #1;
    for (int k = 0; k < 2; k++) begin
      n = (k == 1) ? sb1.size() : sb0.size();
      f = '0;
      if (n > 0) f = (k == 1) ? sb1[0] : sb0[0];
      exp_ir = (k == 1) ? (n < 2) : (n == 0 || ordy);
      checks++;
      if (ov[k] !== (n != 0)) begin
        errors++; $display("FAIL sb_valid skid=%0d got=%b exp=%b t=%0t", k, ov[k], (n != 0), $time);
      end
      checks++;
      if (occ[k] !== 2'(n)) begin
        errors++; $display("FAIL sb_occ skid=%0d got=%0d exp=%0d t=%0t", k, occ[k], n, $time);
      end
      checks++;
      if (ir[k] !== exp_ir) begin
        errors++; $display("FAIL sb_in_ready skid=%0d got=%b exp=%b t=%0t", k, ir[k], exp_ir, $time);
      end
      checks++;
      if (oc[k] !== f[35:32]) begin
        errors++; $display("FAIL sb_ctrl skid=%0d got=%h exp=%h t=%0t", k, oc[k], f[35:32], $time);
      end
      if (n > 0) begin
        checks++;
        if (od[k] !== f[31:0]) begin
          errors++; $display("FAIL sb_data skid=%0d got=%h exp=%h t=%0t", k, od[k], f[31:0], $time);
        end
      end
      acc[k] = iv && ir[k];
      drn[k] = ov[k] && ordy;
    end
    @(posedge clk);
    if (flush) begin
      sb1.delete();
      sb0.delete();
    end else begin
      if (drn[1] && sb1.size() > 0) void'(sb1.pop_front());
      if (drn[0] && sb0.size() > 0) void'(sb0.pop_front());
      if (acc[1]) sb1.push_back({ic, id});
      if (acc[0]) sb0.push_back({ic, id});
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] c,
                       input logic r, input logic f);
    iv = v; id = d; ic = c; ordy = r; flush = f;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #12;
    checks++;
    if (ov !== 2'b00 || occ[1] !== 2'd0 || oc[1] !== 4'h0 || od[1] !== 32'h0) begin
      errors++; $display("FAIL reset_state ov=%b occ=%0d ctrl=%h data=%h exp 0", ov, occ[1], oc[1], od[1]);
    end
    checks++;
    if (ir !== 2'b11) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=11", ir);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // Fill SKID=1 to occupancy 2, then reset asynchronously mid-cycle.
    drive(1'b1, 32'h11, 4'h3, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h22, 4'h5, 1'b0, 1'b0);
    step();
    checks++;
    if (occ[1] !== 2'd2) begin
      errors++; $display("FAIL reset_prefill occ got=%0d exp=2", occ[1]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    sb1.delete();
    sb0.delete();
    checks++;
    if (ov !== 2'b00 || oc[1] !== 4'h0 || occ[1] !== 2'd0) begin
      errors++; $display("FAIL reset_async ov=%b ctrl=%h occ=%0d exp 0", ov, oc[1], occ[1]);
    end
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (ir !== 2'b11) begin
      errors++; $display("FAIL reset_release_ready got=%b exp=11", ir);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 32'(i), 4'(i), 1'b1, 1'b0);
      step();
      checks++;
      if (od[1] !== 32'(i) || od[0] !== 32'(i) || occ[1] !== 2'd1 || occ[0] !== 2'd1) begin
        errors++; $display("FAIL stream i=%0d got=%h/%h occ=%0d/%0d exp=%h occ 1", i, od[1], od[0], occ[1], occ[0], i);
      end
    end
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] seen[$];
    int          budget;
    drive(1'b1, 32'hA, 4'h1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB, 4'h2, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hC, 4'h4, 1'b0, 1'b0);
    #1;
    checks++;
    if (ir[1] !== 1'b0 || occ[1] !== 2'd2) begin
      errors++; $display("FAIL bp_full in_ready=%b occ=%0d exp 0 and 2", ir[1], occ[1]);
    end
    step();
    ordy = 1'b1;
    budget = 0;
    // Hold 0xC until the skid instance takes it.
    while (budget < 20) begin
      #1;
      if (ov[1]) seen.push_back(od[1]);
      if (ir[1] && iv) begin
        step();
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      end else begin
        step();
      end
      budget++;
      if (!iv && !ov[1]) break;
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 32'hA || seen[1] !== 32'hB || seen[2] !== 32'hC) begin
      errors++; $display("FAIL bp_order got_n=%0d exp=3 (A,B,C)", seen.size());
    end
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h1, 4'hF, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h2, 4'hF, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hD, 4'hF, 1'b0, 1'b1);
    step();
    checks++;
    if (ov !== 2'b00 || oc[1] !== 4'h0 || occ[1] !== 2'd0 || ir !== 2'b11) begin
      errors++; $display("FAIL flush ov=%b ctrl=%h occ=%0d ir=%b exp 00,0,0,11", ov, oc[1], occ[1], ir);
    end
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ov !== 2'b00) begin
        errors++; $display("FAIL flush_no_d ov=%b data=%h exp ov=00", ov, od[1]);
      end
    end
  endtask

  task automatic test_noskid();
    drive(1'b1, 32'h51, 4'h6, 1'b0, 1'b0);
    step();
    #1;
    checks++;
    if (ir[0] !== 1'b0) begin
      errors++; $display("FAIL noskid_stall in_ready got=%b exp=0", ir[0]);
    end
    ordy = 1'b1;
    #1;
    checks++;
    if (ir[0] !== 1'b1) begin
      errors++; $display("FAIL noskid_comb in_ready got=%b exp=1", ir[0]);
    end
    drive(1'b1, 32'h52, 4'h7, 1'b1, 1'b0);
    step();
    checks++;
    if (od[0] !== 32'h52 || oc[0] !== 4'h7 || occ[0] !== 2'd1) begin
      errors++; $display("FAIL noskid_replace data=%h ctrl=%h occ=%0d exp 52,7,1", od[0], oc[0], occ[0]);
    end
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    step();
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
      step();
    end
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (sb1.size() != 0 || sb0.size() != 0 || ov !== 2'b00) begin
      errors++; $display("FAIL random_drain left=%0d/%0d ov=%b exp empty", sb1.size(), sb0.size(), ov);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_noskid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
